// File: rtl/load_store_unit_if.sv
// Request, memory and write-back signals of the load/store unit, bundled as one bus.
// The slave modport is the unit itself; master is the pipeline plus data RAM around it.
interface load_store_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 16
);
    localparam int NB = XLEN / 8;

    logic              HALT;
    logic              LSU_VALID;
    logic              LSU_READY;
    logic              LSU_WE;
    logic [1:0]        LSU_SIZE;
    logic              LSU_UNSIGNED;
    logic [XLEN-1:0]   LSU_ADDR;
    logic [XLEN-1:0]   LSU_WDATA;
    logic [4:0]        LSU_RD;
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [NB-1:0]     MEM_BE;
    logic [XLEN-1:0]   MEM_WDATA;
    logic [XLEN-1:0]   MEM_RDATA;
    logic              MEM_ACK;
    logic              WB_VALID;
    logic [4:0]        WB_RD;
    logic [XLEN-1:0]   WB_DATA;
    logic              LSU_DONE;
    logic [1:0]        LSU_FAULT;

    modport slave (
        input  HALT, LSU_VALID, LSU_WE, LSU_SIZE, LSU_UNSIGNED, LSU_ADDR, LSU_WDATA, LSU_RD,
        input  MEM_RDATA, MEM_ACK,
        output LSU_READY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA,
        output WB_VALID, WB_RD, WB_DATA, LSU_DONE, LSU_FAULT
    );

    modport master (
        output HALT, LSU_VALID, LSU_WE, LSU_SIZE, LSU_UNSIGNED, LSU_ADDR, LSU_WDATA, LSU_RD,
        output MEM_RDATA, MEM_ACK,
        input  LSU_READY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA,
        input  WB_VALID, WB_RD, WB_DATA, LSU_DONE, LSU_FAULT
    );
endinterface

// File: rtl/load_store_unit.sv
// Handshaked memory-access stage: alignment checks, lane byte enables and replication,
// req/ack memory access with a timeout watchdog, and one-cycle result/done/fault strobes.
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input logic               CK_REF,
    input logic               int_rst_n,
    load_store_unit_if.slave  bus
);
    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_FAULT} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;
    typedef enum logic [1:0] {F_NONE, F_MISALIGN, F_SIZE, F_TIMEOUT} fault_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              wb_valid_d, done_d;
    fault_t            fault_q, fault_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              start_req, capture_wb;

    logic              we_q, uns_q;
    size_t             size_q;
    logic [OB-1:0]     off_q;
    logic [4:0]        rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NB-1:0]     be_q;
    logic [XLEN-1:0]   wdata_q;
    logic              wb_valid_q, done_q;
    logic [4:0]        wb_rd_q;
    logic [XLEN-1:0]   wb_data_q;

    size_t             req_size;
    logic [OB-1:0]     req_off;
    logic              illegal_size, misaligned;
    logic [NB-1:0]     be_base;
    logic [XLEN-1:0]   wdata_rep;
    logic [XLEN-1:0]   rd_shift, rd_mask, load_ext;
    logic              rd_msb;
    logic              unused_addr_bits;

    assign req_size         = size_t'(bus.LSU_SIZE);
    assign req_off          = bus.LSU_ADDR[OB-1:0];
    assign illegal_size     = (req_size == SZ_D) && (XLEN == 32);
    assign unused_addr_bits = ^bus.LSU_ADDR[XLEN-1:ADDR_W];

    // Request-side decode: alignment, lane enables and store-data replication.
    always_comb begin
        misaligned = 1'b0;
        be_base    = '1;
        wdata_rep  = bus.LSU_WDATA;
        case (req_size)
            SZ_B: begin
                be_base   = NB'(1);
                wdata_rep = {NB{bus.LSU_WDATA[7:0]}};
            end
            SZ_H: begin
                misaligned = req_off[0];
                be_base    = NB'(3);
                wdata_rep  = {(NB/2){bus.LSU_WDATA[15:0]}};
            end
            SZ_W: begin
                misaligned = |req_off[1:0];
                be_base    = NB'(15);
                wdata_rep  = {(NB/4){bus.LSU_WDATA[31:0]}};
            end
            default: misaligned = |req_off;
        endcase
    end

    // Load alignment: bring the addressed lane to bit 0, then sign- or zero-extend.
    always_comb begin
        rd_shift = bus.MEM_RDATA >> {off_q, 3'b000};
        case (size_q)
            SZ_B:    begin rd_mask = XLEN'(64'hFF);        rd_msb = rd_shift[7];      end
            SZ_H:    begin rd_mask = XLEN'(64'hFFFF);      rd_msb = rd_shift[15];     end
            SZ_W:    begin rd_mask = XLEN'(64'hFFFF_FFFF); rd_msb = rd_shift[31];     end
            default: begin rd_mask = '1;                   rd_msb = rd_shift[XLEN-1]; end
        endcase
        load_ext = (rd_shift & rd_mask) | ({XLEN{rd_msb & ~uns_q}} & ~rd_mask);
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        done_d     = 1'b0;
        fault_d    = F_NONE;
        start_req  = 1'b0;
        capture_wb = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.LSU_VALID && !bus.HALT) begin
                    cnt_d = '0;
                    if (illegal_size) begin
                        state_d = S_FAULT;
                        fault_d = F_SIZE;
                    end else if (misaligned) begin
                        state_d = S_FAULT;
                        fault_d = F_MISALIGN;
                    end else begin
                        state_d   = S_REQ;
                        req_d     = 1'b1;
                        start_req = 1'b1;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 16'd1;
                // An acknowledge on the timeout edge still completes normally.
                if (bus.MEM_ACK) begin
                    state_d    = S_RESP;
                    req_d      = 1'b0;
                    done_d     = we_q;
                    wb_valid_d = !we_q;
                    capture_wb = !we_q;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    fault_d = F_TIMEOUT;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state and outputs update with non-blocking assignments so every register
    // samples the pre-edge value of its neighbours; the async reset drops MEM_REQ at once.
    always_ff @(posedge CK_REF or negedge int_rst_n) begin
        if (!int_rst_n) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            cnt_q      <= '0;
            fault_q    <= F_NONE;
            wb_valid_q <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= SZ_B;
            off_q      <= '0;
            rd_q       <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
            wb_valid_q <= wb_valid_d;
            done_q     <= done_d;
            if (start_req) begin
                we_q    <= bus.LSU_WE;
                uns_q   <= bus.LSU_UNSIGNED;
                size_q  <= req_size;
                off_q   <= req_off;
                rd_q    <= bus.LSU_RD;
                addr_q  <= {bus.LSU_ADDR[ADDR_W-1:OB], {OB{1'b0}}};
                be_q    <= be_base << req_off;
                wdata_q <= wdata_rep;
            end
            if (capture_wb) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= load_ext;
            end
        end
    end

    assign bus.LSU_READY = (state_q == S_IDLE);
    assign bus.MEM_REQ   = req_q;
    assign bus.MEM_WE    = we_q;
    assign bus.MEM_ADDR  = addr_q;
    assign bus.MEM_BE    = be_q;
    assign bus.MEM_WDATA = wdata_q;
    assign bus.WB_VALID  = wb_valid_q;
    assign bus.WB_RD     = wb_rd_q;
    assign bus.WB_DATA   = wb_data_q;
    assign bus.LSU_DONE  = done_q;
    assign bus.LSU_FAULT = fault_q;
endmodule
